// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
//   AHB-Lite responder in front of a word-organised on-chip SRAM. Accepts one
//   address phase per completing cycle, stretches each OKAY data phase by
//   WAIT_STATES low HREADYOUT cycles, applies byte-lane write strobes and
//   answers illegal transfers with the two-cycle ERROR response.
//
// Parameters
//   ADDR_WIDTH   word-address bits (depth = 2**ADDR_WIDTH words of 32 bits)
//   WAIT_STATES  HREADYOUT-low cycles inserted per OKAY data phase (0..15)
//
// Ports
//   HCLK       in   clock
//   HRESETn    in   synchronous active-low reset
//   HSEL       in   slave select from the matrix decoder
//   HADDR      in   32-bit slave-local byte address
//   HTRANS     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HSIZE      in   transfer size (0=byte 1=half 2=word)
//   HWRITE     in   1 = write
//   HWDATA     in   write data, valid in the data phase
//   HREADY     in   bus-level ready returned by the matrix
//   HREADYOUT  out  slave ready (registered)
//   HRESP      out  0 = OKAY, 1 = ERROR (registered)
//   HRDATA     out  read data, zero outside a read data phase
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("ahb_lite_sram_slave: WAIT_STATES must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;

    // Data-phase registers captured from the accepted address phase.
    logic                    vld_p1;
    logic                    write_p1;
    logic [ADDR_WIDTH-1:0]   idx_p1;
    logic [1:0]              size_p1;
    logic [1:0]              lane_p1;

    logic [31:0]             mem [2**ADDR_WIDTH];

    logic                    accept;
    logic                    illegal;
    logic                    write_now;
    logic [3:0]              be;
    logic                    unused_htrans;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] en;
        case (size)
            2'd0:    en = 4'b0001 << lane;
            2'd1:    en = lane[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // HTRANS[0] only distinguishes BUSY from IDLE and SEQ from NONSEQ,
    // which makes no difference to a single-word SRAM.
    assign unused_htrans = HTRANS[0];

    assign accept  = HSEL && HTRANS[1] && HREADY;
    assign illegal = (HSIZE > 3'd2)
                  || ((HSIZE == 3'd1) && HADDR[0])
                  || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                  || ((HADDR >> (ADDR_WIDTH + 2)) != 32'd0);

    // A data phase completes in the first cycle HREADYOUT is high after accept.
    assign write_now = vld_p1 && write_p1 && HREADYOUT;
    assign be        = byte_en(size_p1, lane_p1);

    // ---- address phase -> data phase ----
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            cnt       <= 4'd0;
            vld_p1    <= 1'b0;
            write_p1  <= 1'b0;
            idx_p1    <= '0;
            size_p1   <= 2'd0;
            lane_p1   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    // Both states present HREADYOUT=1, so a new address
                    // phase may be taken while the previous one completes.
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    vld_p1    <= 1'b0;
                    if (accept) begin
                        if (illegal) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else begin
                            vld_p1   <= 1'b1;
                            write_p1 <= HWRITE;
                            idx_p1   <= HADDR[ADDR_WIDTH+1:2];
                            size_p1  <= HSIZE[1:0];
                            lane_p1  <= HADDR[1:0];
                            if (WAIT_STATES > 0) begin
                                state     <= ST_WAIT;
                                HREADYOUT <= 1'b0;
                                cnt       <= WS_INIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    // ---- data phase: SRAM write at the completing edge ----
    always_ff @(posedge HCLK) begin
        if (HRESETn && write_now) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx_p1][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = (vld_p1 && !write_p1) ? mem[idx_p1] : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
//   Two instances (WAIT_STATES=1 and WAIT_STATES=0) share one bus driver;
//   only the selected one sees HSEL. A transaction-level model predicts the
//   ready/response/read-data of the selected slave for every cycle.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        string       nm;
        logic [31:0] got;
        logic [31:0] exp;
    } lit_t;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    bit          d;            // 0: WAIT_STATES=1 instance, 1: WAIT_STATES=0 instance

    logic        rdy1, resp1, rdy0, resp0;
    logic [31:0] rd1, rd0;
    logic        dut_rdy, dut_resp;
    logic [31:0] dut_rd;

    always #5 clk = ~clk;

    ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_ws1 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && !d), .HADDR(haddr),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
        .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && d), .HADDR(haddr),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0)
    );

    assign dut_rdy  = d ? rdy0  : rdy1;
    assign dut_resp = d ? resp0 : resp1;
    assign dut_rd   = d ? rd0   : rd1;

    // Model memory per instance plus known-byte masks (SRAM is not reset).
    logic [31:0] mm [2][DEPTH];
    logic [3:0]  km [2][DEPTH];

    // Pending data phase of the selected slave.
    bit          p_v, p_err, p_wr;
    logic [31:0] p_addr, p_data;
    logic [2:0]  p_size;
    int          p_left;

    // Expectations for the current cycle.
    bit          e_valid, started;
    bit          e_rdy, e_resp, e_rdcomp;
    logic [31:0] e_data, e_mask;

    xfer_t       xq[$];
    xfer_t       cur;
    lit_t        lit_q[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          low_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] last_rd = 32'd0;

    function automatic bit is_illegal(logic [31:0] a, logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
        if (a >= 32'(DEPTH * 4)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic xfer_t mk(bit wr, logic [31:0] a, logic [2:0] s,
                                 logic [31:0] dt, logic [1:0] tr = 2'b10);
        xfer_t x;
        x.sel = 1'b1; x.trans = tr; x.wr = wr; x.addr = a; x.size = s; x.data = dt;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r;
        x.sel = ($urandom_range(0, 9) != 0);
        r = int'($urandom_range(0, 7));
        x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'($urandom_range(2, 3));
        x.wr = 1'($urandom_range(0, 1));
        x.size = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) x.size = 3'($urandom_range(3, 7));
        x.addr = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 9) != 0 && x.size <= 3'd2)
            x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        if ($urandom_range(0, 19) == 0)
            x.addr = x.addr | (32'h1000 << $urandom_range(0, 19));
        x.data = $urandom();
        return x;
    endfunction

    task automatic commit(int di, logic [31:0] a, logic [2:0] s, logic [31:0] wd);
        int w;
        int b0;
        w  = int'(a >> 2);
        b0 = int'(a % 32'd4);
        for (int k = 0; k < (1 << s); k++) begin
            mm[di][w][8*(b0+k) +: 8] = wd[8*(b0+k) +: 8];
            km[di][w][b0+k] = 1'b1;
        end
    endtask

    task automatic compute_expect();
        int w;
        e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'd0; e_mask = 32'hFFFF_FFFF; e_rdcomp = 1'b0;
        if (p_v) begin
            e_rdy = (p_left == 0);
            if (p_err) begin
                e_resp = 1'b1;
            end else if (!p_wr) begin
                if (e_rdy) begin
                    w = int'(p_addr >> 2);
                    e_data = mm[d][w];
                    e_mask = {{8{km[d][w][3]}}, {8{km[d][w][2]}}, {8{km[d][w][1]}}, {8{km[d][w][0]}}};
                    e_rdcomp = 1'b1;
                end else begin
                    e_mask = 32'd0;
                end
            end
        end
    endtask

    task automatic step(input bit rst_n_v);
        compute_expect();
        e_valid = started;
        hresetn = rst_n_v;
        hwdata  = (p_v && !p_err && p_wr) ? p_data : $urandom();
        if (!rst_n_v) begin
            hsel = 1'($urandom); haddr = $urandom(); htrans = 2'($urandom);
            hsize = 3'($urandom); hwrite = 1'($urandom);
        end else if (e_rdy) begin
            if (xq.size() > 0) cur = xq.pop_front();
            else cur = mk(1'($urandom_range(0, 1)), $urandom(), 3'($urandom), $urandom(), 2'b00);
            hsel = cur.sel; haddr = cur.addr; htrans = cur.trans; hsize = cur.size; hwrite = cur.wr;
        end else if (p_v && p_err && p_left == 1 && $urandom_range(0, 1) == 1) begin
            htrans = 2'b00;   // master abandons the transfer while the error is signalled
        end
        @(posedge clk);
        started = 1'b1;
        if (!rst_n_v) begin
            p_v = 1'b0;
        end else if (e_rdy) begin
            if (p_v && !p_err && p_wr) commit(int'(d), p_addr, p_size, hwdata);
            if (hsel && htrans[1]) begin
                p_v = 1'b1; p_wr = hwrite; p_addr = haddr; p_size = hsize; p_data = cur.data;
                p_err = is_illegal(haddr, hsize);
                p_left = p_err ? 1 : (d ? 0 : 1);
            end else begin
                p_v = 1'b0;
            end
        end else begin
            p_left = p_left - 1;
        end
        #1;
    endtask

    task automatic run_queue();
        int guard;
        guard = 0;
        while ((xq.size() > 0 || p_v) && guard < 5000) begin
            step(1'b1);
            guard++;
        end
        if (guard >= 5000) lit_q.push_back('{"run_queue_bound", 32'(guard), 32'd0});
        step(1'b1);
    endtask

    task automatic lit(string nm, logic [31:0] got, logic [31:0] exp);
        lit_q.push_back('{nm, got, exp});
    endtask

    // Single compare process: per-cycle model checks and literal checks.
    always @(negedge clk) begin
        if (e_valid) begin
            n_chk += 3;
            if (dut_rdy !== e_rdy) begin
                n_fail++;
                $display("FAIL hreadyout t=%0t: got %b expected %b", $time, dut_rdy, e_rdy);
            end
            if (dut_resp !== e_resp) begin
                n_fail++;
                $display("FAIL hresp t=%0t: got %b expected %b", $time, dut_resp, e_resp);
            end
            if ((dut_rd & e_mask) !== (e_data & e_mask)) begin
                n_fail++;
                $display("FAIL hrdata t=%0t: got 0x%08h expected 0x%08h (mask 0x%08h)",
                         $time, dut_rd, e_data, e_mask);
            end
            if (dut_rdy === 1'b0) low_cnt++;
            if (dut_resp === 1'b1) resp_cnt++;
            if (e_rdcomp) last_rd = dut_rd;
        end
        while (lit_q.size() > 0) begin
            lit_t l;
            l = lit_q.pop_front();
            n_chk++;
            if (l.got !== l.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", l.nm, l.got, l.exp);
            end
        end
    end

    initial begin
        int l0, r0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++) km[i][j] = 4'd0;
        d = 1'b0; started = 1'b0; e_valid = 1'b0; p_v = 1'b0; p_left = 0;
        hresetn = 1'b0; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00;
        hsize = 3'd0; hwrite = 1'b0; hwdata = 32'd0;
        cur = mk(1'b0, 32'd0, 3'd0, 32'd0, 2'b00);

        // Reset with random bus activity.
        repeat (3) step(1'b0);
        step(1'b1);

        // Back-to-back write/read of one word, one wait state.
        l0 = low_cnt;
        xq.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        xq.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        run_queue();
        lit("ws1_rw_low_cycles", 32'(low_cnt - l0), 32'd2);
        lit("ws1_rw_rdata", last_rd, 32'hDEADBEEF);
        lit("model_word_0x10", mm[0][4], 32'hDEADBEEF);

        // Byte and halfword strobes.
        l0 = low_cnt;
        xq.push_back(mk(1'b1, 32'h20, 3'd0, 32'h0000_0011));
        xq.push_back(mk(1'b1, 32'h21, 3'd0, 32'h0000_2200));
        xq.push_back(mk(1'b1, 32'h22, 3'd0, 32'h0033_0000));
        xq.push_back(mk(1'b1, 32'h23, 3'd0, 32'h4400_0000));
        xq.push_back(mk(1'b1, 32'h22, 3'd1, 32'hAA55_0000));
        xq.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0));
        run_queue();
        lit("lanes_rdata", last_rd, 32'hAA552211);
        lit("lanes_low_cycles", 32'(low_cnt - l0), 32'd6);
        lit("model_word_0x20", mm[0][8], 32'hAA552211);

        // Illegal transfers: misaligned read, HSIZE=3, misaligned write.
        l0 = low_cnt; r0 = resp_cnt;
        xq.push_back(mk(1'b0, 32'h02, 3'd2, 32'd0));
        xq.push_back(mk(1'b0, 32'h10, 3'd3, 32'd0));
        xq.push_back(mk(1'b1, 32'h12, 3'd2, 32'h0BADF00D));
        xq.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
        run_queue();
        lit("err_resp_cycles", 32'(resp_cnt - r0), 32'd6);
        lit("err_low_cycles", 32'(low_cnt - l0), 32'd4);
        lit("err_mem_unchanged", last_rd, 32'hDEADBEEF);

        // Reset during the wait state of a write.
        xq.push_back(mk(1'b1, 32'h40, 3'd2, 32'h12345678));
        run_queue();
        xq.push_back(mk(1'b1, 32'h40, 3'd2, 32'hFFFFFFFF));
        step(1'b1);
        step(1'b0);
        xq.push_back(mk(1'b0, 32'h40, 3'd2, 32'd0));
        run_queue();
        lit("reset_drops_write", last_rd, 32'h12345678);

        // Randomized traffic, WAIT_STATES=1.
        repeat (250) xq.push_back(rand_xfer());
        run_queue();

        // Zero-wait streaming: 8 writes then 8 reads.
        d = 1'b1;
        step(1'b1);
        l0 = low_cnt;
        for (int i = 0; i < 8; i++)
            xq.push_back(mk(1'b1, 32'(4 * i), 3'd2, 32'hA5000000 + 32'(i), (i == 0) ? 2'b10 : 2'b11));
        for (int i = 0; i < 8; i++)
            xq.push_back(mk(1'b0, 32'(4 * i), 3'd2, 32'd0, (i == 0) ? 2'b10 : 2'b11));
        run_queue();
        lit("ws0_stream_low_cycles", 32'(low_cnt - l0), 32'd0);
        lit("ws0_stream_last_rdata", last_rd, 32'hA5000007);

        // Randomized traffic, WAIT_STATES=0.
        repeat (250) xq.push_back(rand_xfer());
        run_queue();

        repeat (3) step(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
